// File: rtl/cnt_arb_pkg.sv
// Shared types and helpers for the count_enable_arbiter slice.
package cnt_arb_pkg;

  typedef enum logic [1:0] {IDLE, RUN, GAP} state_t;

  // Successor of idx in a ring of n entries.
  function automatic int unsigned ptr_wrap(int unsigned idx, int unsigned n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request at or above ptr, wrapping to 0.
module rr_pick #(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]         req,
  input  logic [$clog2(NUM_REQ)-1:0] ptr,
  output logic                       valid,
  output logic [$clog2(NUM_REQ)-1:0] winner
);
  localparam int IW = $clog2(NUM_REQ);

  int            sum;
  logic [IW-1:0] sel;
  logic          found;

  always_comb begin
    valid  = |req;
    winner = '0;
    found  = 1'b0;
    sum    = 0;
    sel    = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      sum = int'(ptr) + k;
      if (sum >= NUM_REQ) sum = sum - NUM_REQ;
      sel = IW'(sum);
      if (!found && req[sel]) begin
        winner = sel;
        found  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/count_enable_arbiter.sv
// Round-robin arbiter gating a shared up-counter enable for fixed bursts.
// Optional early release of a burst when the owner drops its request: CNT_ARB_EARLY_RELEASE_EN.
module count_enable_arbiter
  import cnt_arb_pkg::*;
#(
  parameter int NUM_REQ   = 4,
  parameter int BURST_LEN = 5
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req,
  output logic [NUM_REQ-1:0]         grant,
  output logic [$clog2(NUM_REQ)-1:0] grant_id,
  output logic                       cnt_enable,
  output logic                       busy,
  output logic                       done,
  output logic [$clog2(NUM_REQ)-1:0] done_id,
  output logic                       early
);
  localparam int IW = $clog2(NUM_REQ);
  localparam int BW = $clog2(BURST_LEN + 1);

  state_t        state_reg, state_next;
  logic [IW-1:0] winner_reg, winner_next;
  logic [IW-1:0] ptr_reg, ptr_next;
  logic [BW-1:0] beat_reg, beat_next;
  logic          early_reg, early_next;
  logic          pick_valid;
  logic [IW-1:0] pick_winner;
  logic          release_req;

  rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
    .req    (req),
    .ptr    (ptr_reg),
    .valid  (pick_valid),
    .winner (pick_winner)
  );

`ifdef CNT_ARB_EARLY_RELEASE_EN
  assign release_req = ~req[winner_reg];
`else
  assign release_req = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg  <= IDLE;
      winner_reg <= '0;
      ptr_reg    <= '0;
      beat_reg   <= '0;
      early_reg  <= 1'b0;
    end else begin
      state_reg  <= state_next;
      winner_reg <= winner_next;
      ptr_reg    <= ptr_next;
      beat_reg   <= beat_next;
      early_reg  <= early_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    winner_next = winner_reg;
    ptr_next    = ptr_reg;
    beat_next   = beat_reg;
    early_next  = early_reg;
    case (state_reg)
      IDLE: begin
        if (pick_valid) begin
          state_next  = RUN;
          winner_next = pick_winner;
          beat_next   = '0;
          early_next  = 1'b0;
        end
      end
      RUN: begin
        // A last-beat edge is a normal finish even if the owner also released.
        if (beat_reg == BW'(BURST_LEN - 1)) begin
          state_next = GAP;
          early_next = 1'b0;
        end else if (release_req) begin
          state_next = GAP;
          early_next = 1'b1;
        end else begin
          beat_next = beat_reg + 1'b1;
        end
      end
      GAP: begin
        state_next = IDLE;
        ptr_next   = IW'(ptr_wrap(32'(winner_reg), NUM_REQ));
      end
      default: state_next = IDLE;
    endcase
  end

  // Outputs decode straight from registered state so reset clears them immediately.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_grant
      assign grant[gi] = (state_reg == RUN) && (winner_reg == IW'(gi));
    end
  endgenerate

  assign cnt_enable = (state_reg == RUN);
  assign busy       = (state_reg == RUN) || (state_reg == GAP);
  assign done       = (state_reg == GAP);
  assign early      = (state_reg == GAP) && early_reg;
  assign grant_id   = winner_reg;
  assign done_id    = winner_reg;

endmodule

// File: tb/tb_count_enable_arbiter.sv
// Self-checking bench for count_enable_arbiter driving a 4-bit enable counter.
module tb_count_enable_arbiter;
  localparam int NR = 4;
  localparam int BL = 5;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [NR-1:0] req = 4'b1111;
  logic [NR-1:0] grant;
  logic [1:0]    grant_id, done_id;
  logic          cnt_enable, busy, done, early;
  logic [3:0]    count;

  int tests = 0;
  int fails = 0;

  count_enable_arbiter #(.NUM_REQ(NR), .BURST_LEN(BL)) dut (
    .clk(clk), .rst(rst), .req(req), .grant(grant), .grant_id(grant_id),
    .cnt_enable(cnt_enable), .busy(busy), .done(done), .done_id(done_id), .early(early)
  );

  always #5 clk = ~clk;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) count <= 4'd0;
    else if (cnt_enable) count <= count + 4'd1;
  end

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  // Behavioural model: mode 0 idle, 1 burst with m_left enable cycles still to come, 2 done cycle.
  int         m_mode  = 0;
  int         m_left  = 0;
  int         m_owner = 0;
  int         m_ptr   = 0;
  bit         m_early = 0;
  logic [3:0] m_count = 4'd0;

  function automatic int pick(input logic [NR-1:0] r, input int p);
    for (int k = 0; k < NR; k++) if (r[(p + k) % NR]) return (p + k) % NR;
    return -1;
  endfunction

  initial forever begin
    @(posedge clk or posedge rst);
    if (rst) begin
      m_mode = 0; m_left = 0; m_owner = 0; m_ptr = 0; m_early = 0; m_count = 4'd0;
    end else begin
      if (m_mode == 1) m_count = m_count + 4'd1;
      case (m_mode)
        0: if (pick(req, m_ptr) >= 0) begin
             m_owner = pick(req, m_ptr); m_left = BL; m_mode = 1; m_early = 0;
           end
        1: begin
             m_left = m_left - 1;
             if (m_left == 0) m_mode = 2;
`ifdef CNT_ARB_EARLY_RELEASE_EN
             else if (!req[m_owner]) begin m_mode = 2; m_early = 1; end
`endif
           end
        default: begin m_ptr = (m_owner + 1) % NR; m_mode = 0; end
      endcase
    end
  end

  // Per-cycle compare plus transaction logs read back by the directed tests.
  int d_id[$], d_early[$], d_len[$], d_cnt[$], low_q[$];
  int run_len = 0, low_len = 0;
  bit prev_en = 0;

  initial forever begin
    @(negedge clk);
    check("grant",      int'(grant),      (m_mode == 1) ? (1 << m_owner) : 0);
    check("cnt_enable", int'(cnt_enable), int'(m_mode == 1));
    check("busy",       int'(busy),       int'(m_mode != 0));
    check("done",       int'(done),       int'(m_mode == 2));
    check("early",      int'(early),      int'(m_mode == 2 && m_early));
    check("grant_id",   int'(grant_id),   m_owner);
    check("done_id",    int'(done_id),    m_owner);
    check("count",      int'(count),      int'(m_count));
    if (rst) begin
      run_len = 0; low_len = 0; prev_en = 0;
    end else begin
      if (cnt_enable) begin
        if (!prev_en) begin low_q.push_back(low_len); low_len = 0; end
        run_len++;
      end else low_len++;
      prev_en = cnt_enable;
      if (done) begin
        d_id.push_back(int'(done_id)); d_early.push_back(int'(early));
        d_len.push_back(run_len); d_cnt.push_back(int'(count));
        $display("[TB] done id=%0d early=%0d enable_cycles=%0d count=%0d", done_id, early, run_len, count);
        run_len = 0;
      end
    end
  end

  task automatic tick();
    @(negedge clk); #1;
  endtask

  task automatic wait_done(input int n_before, input string name);
    for (int i = 0; i < 40; i++) begin
      tick();
      if (d_id.size() > n_before) return;
    end
    check({name, "_timeout"}, 0, 1);
  endtask

  task automatic wait_en(input string name);
    for (int i = 0; i < 40; i++) begin
      tick();
      if (cnt_enable) return;
    end
    check({name, "_timeout"}, 0, 1);
  endtask

  task automatic expect_done(input string name, input int idx, input int id, input int len,
                             input int erl, input int cnt);
    if (d_id.size() <= idx) begin
      check({name, "_missing"}, d_id.size(), idx + 1);
      return;
    end
    check({name, "_id"}, d_id[idx], id);
    check({name, "_len"}, d_len[idx], len);
    check({name, "_early"}, d_early[idx], erl);
    if (cnt >= 0) check({name, "_count"}, d_cnt[idx], cnt);
  endtask

  initial begin
    int n, lq;
    int ids3[5] = '{0, 1, 2, 3, 0};
    int cnt3[5] = '{5, 10, 15, 4, 9};
    int ids4[3] = '{2, 3, 0};

    // 1: reset with all requests up, then idle with no requests
    tick(); tick();
    check("t1_grant_rst", int'(grant), 0);
    check("t1_en_rst", int'(cnt_enable), 0);
    check("t1_done_rst", int'(done), 0);
    rst = 1'b0; req = 4'b0000;
    tick(); tick(); tick();
    check("t1_idle_busy", int'(busy), 0);
    check("t1_idle_count", int'(count), 0);
    $display("[TB] t1 reset/idle checked");

    // 2: single requester 2
    n = d_id.size();
    req = 4'b0100;
    wait_done(n, "t2");
    req = 4'b0000;
    expect_done("t2", n, 2, BL, 0, 5);

    // 3: all request, from pointer 0
    rst = 1'b1; tick(); rst = 1'b0;
    n = d_id.size(); lq = low_q.size();
    req = 4'b1111;
    for (int b = 0; b < 5; b++) wait_done(n + b, "t3");
    req = 4'b0000;
    for (int b = 0; b < 5; b++) expect_done($sformatf("t3_b%0d", b), n + b, ids3[b], BL, 0, cnt3[b]);
    for (int b = 1; b < 5; b++) begin
      if (low_q.size() > lq + b) check($sformatf("t3_gap%0d", b), low_q[lq + b], 2);
      else check($sformatf("t3_gap%0d_missing", b), low_q.size(), lq + b + 1);
    end

    // 4: burst for 2 moves pointer to 3, then 1001 serves 3 before 0
    tick(); tick();
    n = d_id.size();
    req = 4'b0100;
    wait_done(n, "t4a");
    req = 4'b1001;
    wait_done(n + 1, "t4b");
    wait_done(n + 2, "t4c");
    req = 4'b0000;
    for (int b = 0; b < 3; b++) expect_done($sformatf("t4_b%0d", b), n + b, ids4[b], BL, 0, -1);

    // 5: reset during beat 2 of a burst
    tick();
    req = 4'b0100;
    wait_en("t5_start");
    tick(); tick();
    n = d_id.size();
    rst = 1'b1; req = 4'b0000;
    #1;
    check("t5_grant_async", int'(grant), 0);
    check("t5_en_async", int'(cnt_enable), 0);
    check("t5_busy_async", int'(busy), 0);
    tick();
    rst = 1'b0; req = 4'b0010;
    wait_done(n, "t5");
    req = 4'b0000;
    expect_done("t5_after", n, 1, BL, 0, 5);

    // 6: owner drops its request after two enable cycles
    tick();
    n = d_id.size();
    req = 4'b0001;
    wait_en("t6_start");
    tick();
    req = 4'b0000;
    wait_done(n, "t6");
`ifdef CNT_ARB_EARLY_RELEASE_EN
    expect_done("t6", n, 0, 2, 1, 7);
`else
    expect_done("t6", n, 0, BL, 0, 10);
`endif

    tick(); tick();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
